cpu_clk_ctrl: RTL and testbench
===============================

// Module: cpu_clk_ctrl
// PURPOSE
//  Execution-rate controller for the 32-bit CPU core on the DE0-Nano 50 MHz clock.
//  Replaces a fixed slow clock with a programmable prescaler that emits a one-cycle
//  clock-enable (cpu_ce); the whole design stays on the single clk domain.
//  Sequences the core through HALT / RUN / STEP / BRK modes under debug requests and breakpoint hits.
// PARAMETERS
//  DIV_W        32       prescaler width (bits)
//  DEFAULT_DIV  131071   reset value of divisor-minus-one (tick period 2^17 clk)
//  STEP_W       8        width of single-step count
// PORTS
//  clk        in   1       system clock, 50 MHz
//  rst        in   1       synchronous reset, active-high
//  cfg_wr     in   1       load cfg_div into divisor register (1-cycle pulse)
//  cfg_div    in   DIV_W   tick period minus one
//  run_req    in   1       request free-run (pulse)
//  halt_req   in   1       request halt (pulse)
//  step_req   in   1       request step_n enables then halt (pulse)
//  step_n     in   STEP_W  number of steps for step_req
//  bkpt_hit   in   1       breakpoint match from CPU
//  cpu_ce     out  1       CPU clock enable, one clk cycle wide
//  state      out  2       HALT=0, RUN=1, STEP=2, BRK=3
//  busy       out  1       state is RUN or STEP
//  ce_count   out  32      total cpu_ce pulses issued, wraps at 2^32
// BEHAVIOUR
//  Reset: state=HALT, cpu_ce=0, busy=0, ce_count=0, cnt=0, div_reg=DEFAULT_DIV, step_left=0.
//  Prescaler: cnt free-runs in every state; tick=(cnt==div_reg); on tick cnt<=0 else cnt+1.
//   cfg_wr: div_reg<=cfg_div, cnt<=0, tick suppressed that cycle; legal in any state.
//   cfg_div=0 -> tick every cycle. Increasing div_reg below current cnt is impossible (cnt cleared).
//  Request priority per cycle: halt_req > bkpt_hit > run_req > step_req; unlisted requests ignored.
//  HALT: run_req->RUN; step_req && step_n!=0 -> STEP, step_left<=step_n; step_n==0 ignored.
//   bkpt_hit ignored in HALT.
//  RUN:  halt_req->HALT; bkpt_hit->BRK.
//  STEP: halt_req->HALT, step_left<=0; bkpt_hit->BRK, step_left<=0;
//   else on tick: issue ce, step_left-1; if step_left==1 -> HALT.
//  BRK:  halt_req->HALT; run_req->RUN; step_req && step_n!=0 -> STEP; bkpt_hit held high ignored.
//  cpu_ce is registered: tick in cycle N with state RUN/STEP and no halt_req/bkpt_hit in N
//   -> cpu_ce=1 in N+1 only. Tick in the cycle a mode is entered issues nothing
//   (decision uses current state). Never two consecutive pulses unless div_reg==0.
//  ce_count increments in the cycle cpu_ce is high; cleared only by rst.
//  busy and state are registered, updated with the state register.
//  rst mid-RUN/STEP: all registers to reset values next edge; no cpu_ce after rst.
// TESTING
//  1 rst, run_req, cfg_wr cfg_div=3 -> cpu_ce every 4th clk, ce_count +1 each pulse.
//  2 HALT, cfg_div=1, step_req step_n=3 -> exactly 3 pulses 2 clk apart, then state=HALT, busy=0.
//  3 RUN cfg_div=0, bkpt_hit on a tick cycle -> no cpu_ce next cycle, state=BRK, ce_count frozen.
//  4 RUN cfg_div=9, cfg_wr cfg_div=4 at cnt=7 -> next pulse 5 clk later, then period 5.
//  5 STEP with halt_req and bkpt_hit same cycle -> state=HALT, step_left=0, no pulse.
//  6 rst asserted mid-STEP (step_left=5) -> state=HALT, ce_count=0, cpu_ce=0 thereafter; step_n=0 request ignored.

Source files
------------

// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if: debug/config requests in (master drives), CPU enable and status out (slave drives)
interface cpu_clk_ctrl_if #(
  parameter int DIV_W  = 32,
  parameter int STEP_W = 8
);
  logic              cfg_wr;
  logic [DIV_W-1:0]  cfg_div;
  logic              run_req;
  logic              halt_req;
  logic              step_req;
  logic [STEP_W-1:0] step_n;
  logic              bkpt_hit;
  logic              cpu_ce;
  logic [1:0]        state;
  logic              busy;
  logic [31:0]       ce_count;
  modport master (
    output cfg_wr, cfg_div, run_req, halt_req, step_req, step_n, bkpt_hit,
    input  cpu_ce, state, busy, ce_count
  );
  modport slave (
    input  cfg_wr, cfg_div, run_req, halt_req, step_req, step_n, bkpt_hit,
    output cpu_ce, state, busy, ce_count
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: prescaled CPU clock-enable with HALT/RUN/STEP/BRK sequencing
//   clk, rst : system clock, synchronous active-high reset
//   bus      : cfg_wr/cfg_div, run/halt/step requests, step_n, bkpt_hit in;
//              cpu_ce, state (HALT=0 RUN=1 STEP=2 BRK=3), busy, ce_count out
module cpu_clk_ctrl #(
  parameter int              DIV_W       = 32,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 131071,
  parameter int              STEP_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  cpu_clk_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, BRK = 2'd3} state_t;
  state_t            st, st_n;
  logic [DIV_W-1:0]  cnt, div_reg;
  logic [STEP_W-1:0] step_left, step_left_n;
  logic              tick, ce_n, step_ok;
  // a divisor write restarts the period, so that cycle never ticks
  assign tick    = (cnt == div_reg) && !bus.cfg_wr;
  assign step_ok = bus.step_req && (bus.step_n != '0);
  assign bus.state = st;
  always_comb begin
    st_n        = st;
    step_left_n = step_left;
    ce_n        = 1'b0;
    case (st)
      RUN: begin
        if (bus.halt_req) st_n = HALT;
        else if (bus.bkpt_hit) st_n = BRK;
        else ce_n = tick;
      end
      STEP: begin
        if (bus.halt_req || bus.bkpt_hit) begin
          st_n        = bus.halt_req ? HALT : BRK;
          step_left_n = '0;
        end else if (tick) begin
          ce_n        = 1'b1;
          step_left_n = step_left - STEP_W'(1);
          st_n        = (step_left == STEP_W'(1)) ? HALT : STEP;
        end
      end
      default: begin
        // HALT and BRK both ignore bkpt_hit
        if (bus.halt_req) st_n = HALT;
        else if (bus.run_req) st_n = RUN;
        else if (step_ok) begin
          st_n        = STEP;
          step_left_n = bus.step_n;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= HALT;
      cnt          <= '0;
      div_reg      <= DEFAULT_DIV;
      step_left    <= '0;
      bus.cpu_ce   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.ce_count <= '0;
    end else begin
      st           <= st_n;
      step_left    <= step_left_n;
      bus.cpu_ce   <= ce_n;
      bus.busy     <= (st_n == RUN) || (st_n == STEP);
      bus.ce_count <= bus.ce_count + {31'b0, bus.cpu_ce};
      cnt          <= (bus.cfg_wr || tick) ? '0 : cnt + DIV_W'(1);
      if (bus.cfg_wr) div_reg <= bus.cfg_div;
    end
  end
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed self-checking bench for cpu_clk_ctrl
module tb_cpu_clk_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   n;
  cpu_clk_ctrl_if bus ();
  cpu_clk_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_ce(output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!bus.cpu_ce && cycles < 40);
  endtask
  task automatic count_ce(input int len, output int pulses);
    pulses = 0;
    for (int i = 0; i < len; i++) begin
      cyc();
      if (bus.cpu_ce) pulses++;
    end
  endtask
  task automatic idle();
    bus.cfg_wr = 0; bus.run_req = 0; bus.halt_req = 0;
    bus.step_req = 0; bus.bkpt_hit = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle();
    bus.cfg_div = '0;
    bus.step_n  = '0;
    rst = 1;
    cyc(); cyc();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_ce", 32'(bus.cpu_ce), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_count", bus.ce_count, 0);
    chk("rst_div", dut.div_reg, 131071);
    rst = 0;
    bus.run_req = 1; bus.cfg_wr = 1; bus.cfg_div = 3;
    cyc(); idle();
    chk("run_state", 32'(bus.state), 1);
    chk("run_busy", 32'(bus.busy), 1);
    wait_ce(n);
    chk("div3_first", n, 4);
    chk("div3_cnt0", bus.ce_count, 0);
    wait_ce(n);
    chk("div3_period", n, 4);
    chk("div3_cnt1", bus.ce_count, 1);
    cyc();
    chk("ce_one_wide", 32'(bus.cpu_ce), 0);
    chk("div3_cnt2", bus.ce_count, 2);
    bus.halt_req = 1;
    cyc(); idle();
    chk("halt_state", 32'(bus.state), 0);
    chk("halt_busy", 32'(bus.busy), 0);
    bus.bkpt_hit = 1;
    cyc(); idle();
    chk("halt_ign_bkpt", 32'(bus.state), 0);
    bus.cfg_wr = 1; bus.cfg_div = 1; bus.step_req = 1; bus.step_n = 3;
    cyc(); idle();
    chk("step_state", 32'(bus.state), 2);
    wait_ce(n);
    chk("step_gap1", n, 2);
    chk("step_mid_state", 32'(bus.state), 2);
    wait_ce(n);
    chk("step_gap2", n, 2);
    wait_ce(n);
    chk("step_gap3", n, 2);
    chk("step_done_state", 32'(bus.state), 0);
    chk("step_done_busy", 32'(bus.busy), 0);
    count_ce(8, n);
    chk("step_no_extra", n, 0);
    chk("step_count", bus.ce_count, 5);
    bus.run_req = 1; bus.cfg_wr = 1; bus.cfg_div = 0;
    cyc(); idle();
    cyc();
    chk("div0_ce_a", 32'(bus.cpu_ce), 1);
    cyc();
    chk("div0_ce_b", 32'(bus.cpu_ce), 1);
    chk("div0_count", bus.ce_count, 6);
    bus.bkpt_hit = 1;
    cyc();
    chk("bkpt_no_ce", 32'(bus.cpu_ce), 0);
    chk("bkpt_state", 32'(bus.state), 3);
    chk("bkpt_count", bus.ce_count, 7);
    cyc(); cyc(); cyc();
    chk("brk_frozen", bus.ce_count, 7);
    chk("brk_held", 32'(bus.state), 3);
    bus.run_req = 1;
    cyc(); idle();
    chk("brk_to_run", 32'(bus.state), 1);
    bus.cfg_wr = 1; bus.cfg_div = 9;
    cyc(); idle();
    repeat (7) cyc();
    chk("cnt_at_7", dut.cnt, 7);
    bus.cfg_wr = 1; bus.cfg_div = 4;
    cyc(); idle();
    wait_ce(n);
    chk("rediv_first", n, 5);
    wait_ce(n);
    chk("rediv_period", n, 5);
    bus.halt_req = 1;
    cyc(); idle();
    chk("halt2_state", 32'(bus.state), 0);
    bus.step_req = 1; bus.step_n = 10; bus.cfg_wr = 1; bus.cfg_div = 0;
    cyc(); idle();
    chk("step2_state", 32'(bus.state), 2);
    chk("pre_hb_count", bus.ce_count, 9);
    bus.halt_req = 1; bus.bkpt_hit = 1;
    cyc(); idle();
    chk("hb_state", 32'(bus.state), 0);
    chk("hb_step_left", 32'(dut.step_left), 0);
    chk("hb_no_ce", 32'(bus.cpu_ce), 0);
    count_ce(4, n);
    chk("hb_quiet", n, 0);
    chk("hb_count", bus.ce_count, 9);
    bus.cfg_wr = 1; bus.cfg_div = 9; bus.step_req = 1; bus.step_n = 5;
    cyc(); idle();
    cyc(); cyc();
    chk("pre_rst_left", 32'(dut.step_left), 5);
    chk("pre_rst_state", 32'(bus.state), 2);
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_rst_state", 32'(bus.state), 0);
    chk("mid_rst_count", bus.ce_count, 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_ce", 32'(bus.cpu_ce), 0);
    chk("mid_rst_left", 32'(dut.step_left), 0);
    bus.step_req = 1; bus.step_n = 0;
    cyc(); idle();
    chk("step0_ignored", 32'(bus.state), 0);
    count_ce(20, n);
    chk("post_rst_quiet", n, 0);
    chk("post_rst_count", bus.ce_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
